// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared types and default parameter values for the fetch unit.
// Rev    : 1.0  initial release
// ============================================================================
package fetch_pkg;

    localparam int c_ADDR_W_DEF   = 16;
    localparam int c_INSTR_W_DEF  = 16;
    localparam int c_DEPTH_DEF    = 4;
    localparam int c_RESET_PC_DEF = 0;

    localparam logic [3:0] c_HALT_OPCODE = 4'hF;

    typedef enum logic [0:0] {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module : fetch_fifo
// Brief  : Instruction queue holding each instruction with its fetch address.
// Rev    : 1.0  initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DATA_W = c_INSTR_W_DEF,
    parameter int TAG_W  = c_ADDR_W_DEF,
    parameter int DEPTH  = c_DEPTH_DEF,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic [TAG_W-1:0]  push_tag,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [TAG_W-1:0]  head_tag,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [TAG_W-1:0]  r_mem_tag  [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_data = r_mem_data[r_rd_ptr];
    assign head_tag  = r_mem_tag[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Storage is cleared on reset so the head reads as zero until first written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_tag[i]  <= '0;
            end
        end else if (w_do_push && !flush) begin
            r_mem_data[r_wr_ptr] <= push_data;
            r_mem_tag[r_wr_ptr]  <= push_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : instr_fetch_unit
// Brief  : Credit-limited instruction fetcher with redirect flush and halt.
//          Define FETCH_BYPASS_EN to forward responses straight to an empty queue.
// Rev    : 1.0  initial release
// ============================================================================
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = c_ADDR_W_DEF,
    parameter int                INSTR_W  = c_INSTR_W_DEF,
    parameter int                DEPTH    = c_DEPTH_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(c_RESET_PC_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_rsp_valid,
    input  logic [INSTR_W-1:0] mem_rsp_data,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic               halted
);

    localparam int                CNT_W     = $clog2(DEPTH + 1);
    localparam int                PTR_W     = $clog2(DEPTH);
    localparam int                SUM_W     = CNT_W + 2;
    localparam logic [ADDR_W-1:0] c_PC_STEP = ADDR_W'(INSTR_W / 8);

    fetch_state_e       r_state;
    fetch_state_e       w_state_nxt;
    logic               r_active;
    logic [ADDR_W-1:0]  r_pc;
    logic [CNT_W-1:0]   r_outstanding;
    logic [CNT_W-1:0]   r_discard;
    logic [ADDR_W-1:0]  r_tag_mem [DEPTH];
    logic [PTR_W-1:0]   r_tag_wr;
    logic [PTR_W-1:0]   r_tag_rd;
    logic [CNT_W-1:0]   w_count;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [INSTR_W-1:0] w_head_instr;
    logic [ADDR_W-1:0]  w_head_pc;
    logic [ADDR_W-1:0]  w_rsp_pc;
    logic [SUM_W-1:0]   w_inflight;
    logic [SUM_W-1:0]   w_discard_sum;
    logic               w_credit_ok;
    logic               w_req_fire;
    logic               w_rsp_keep;
    logic               w_rsp_drop;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;

    // Every slot that a queued, outstanding or to-be-discarded response may need is reserved.
    assign w_inflight  = SUM_W'(w_count) + SUM_W'(r_outstanding) + SUM_W'(r_discard);
    assign w_credit_ok = (w_inflight < SUM_W'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= FETCH;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        mem_req_valid = 1'b0;
        if (halt)                w_state_nxt = HALTED;
        else if (redirect_valid) w_state_nxt = FETCH;
        if (r_active && (r_state == FETCH) && w_credit_ok) mem_req_valid = 1'b1;
    end

    assign halted        = (r_state == HALTED);
    assign mem_addr      = r_pc;
    assign w_req_fire    = mem_req_valid & mem_req_ready;
    assign w_rsp_drop    = mem_rsp_valid & (r_discard != '0);
    assign w_rsp_keep    = mem_rsp_valid & (r_discard == '0) & ~redirect_valid;
    assign w_rsp_pc      = r_tag_mem[r_tag_rd];
    assign w_discard_sum = SUM_W'(r_discard) + SUM_W'(r_outstanding)
                         + SUM_W'(w_req_fire) - SUM_W'(mem_rsp_valid);

`ifdef FETCH_BYPASS_EN
    assign w_bypass = w_rsp_keep & w_fifo_empty;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push      = w_rsp_keep & ~(w_bypass & instr_ready) & ~w_fifo_full;
    assign w_pop       = ~w_fifo_empty & instr_ready & ~redirect_valid;
    assign instr_valid = ~w_fifo_empty | w_bypass;
    assign instr       = w_bypass ? mem_rsp_data : w_head_instr;
    assign instr_pc    = w_bypass ? w_rsp_pc : w_head_pc;

    // r_active holds requests off until the first edge after reset releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active      <= 1'b0;
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_tag_wr      <= '0;
            r_tag_rd      <= '0;
        end else begin
            r_active <= 1'b1;
            if (redirect_valid) begin
                r_pc          <= redirect_pc;
                r_outstanding <= '0;
                r_discard     <= w_discard_sum[CNT_W-1:0];
                r_tag_wr      <= '0;
                r_tag_rd      <= '0;
            end else begin
                if (w_req_fire) r_pc <= r_pc + c_PC_STEP;
                r_outstanding <= r_outstanding + CNT_W'(w_req_fire) - CNT_W'(w_rsp_keep);
                if (w_rsp_drop) r_discard <= r_discard - CNT_W'(1);
                if (w_req_fire) r_tag_wr <= r_tag_wr + PTR_W'(1);
                if (w_rsp_keep) r_tag_rd <= r_tag_rd + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_req_fire && !redirect_valid) r_tag_mem[r_tag_wr] <= r_pc;
    end

    fetch_fifo #(
        .DATA_W (INSTR_W),
        .TAG_W  (ADDR_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (w_push),
        .push_data (mem_rsp_data),
        .push_tag  (w_rsp_pc),
        .pop       (w_pop),
        .head_data (w_head_instr),
        .head_tag  (w_head_pc),
        .count     (w_count),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_fetch_unit
// Brief  : Self-checking bench: in-order memory model plus an expected-stream model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [15:0] mem_addr;
    logic        mem_rsp_valid;
    logic [15:0] mem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        halted;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // memory model: in-order queue of (address, due cycle)
    logic [15:0] mq_addr[$];
    int          mq_due[$];
    int          lat     = 1;
    int          rdy_pct = 100;
    logic [15:0] key     = 16'h5A5A;

    logic        drv_instr_ready, drv_redirect, drv_halt;
    logic [15:0] drv_redirect_pc;

    logic        o_req, o_cons, o_ivalid, o_rvalid, o_halted;
    logic [15:0] o_req_addr, o_instr, o_pc;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W   (16),
        .INSTR_W  (16),
        .DEPTH    (4),
        .RESET_PC (16'h0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .halted         (halted)
    );

    task automatic clear_drives();
        drv_instr_ready = 1'b0;
        drv_redirect    = 1'b0;
        drv_halt        = 1'b0;
        drv_redirect_pc = 16'h0000;
    endtask

    // One clock: drive after the falling edge, sample, then commit memory model at the rising edge.
    task automatic cycle();
        @(negedge clk);
        mem_req_ready  = ($urandom_range(99) < rdy_pct);
        mem_rsp_valid  = (mq_due.size() > 0) && (mq_due[0] <= cyc);
        mem_rsp_data   = 16'($urandom);
        if (mem_rsp_valid) mem_rsp_data = mq_addr[0] ^ key;
        instr_ready    = drv_instr_ready;
        redirect_valid = drv_redirect;
        redirect_pc    = drv_redirect_pc;
        halt           = drv_halt;
        #1;
        o_rvalid   = mem_req_valid;
        o_req      = mem_req_valid & mem_req_ready;
        o_req_addr = mem_addr;
        o_ivalid   = instr_valid;
        o_cons     = instr_valid & instr_ready & ~redirect_valid;
        o_instr    = instr;
        o_pc       = instr_pc;
        o_halted   = halted;
        @(posedge clk);
        if (mem_rsp_valid) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (o_req) begin
            mq_addr.push_back(o_req_addr);
            mq_due.push_back(cyc + lat);
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 16'h0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0; halt = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        clear_drives();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", mem_req_valid); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        checks++; if (instr !== 16'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0000", instr); end
        checks++; if (instr_pc !== 16'h0) begin errors++; $display("FAIL reset_instr_pc: got %h expected 0000", instr_pc); end
        checks++; if (mem_addr !== 16'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0000", mem_addr); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL release_req_valid: got %b expected 0", mem_req_valid); end
        rdy_pct = 0;
        cycle();
        checks++; if (o_rvalid !== 1'b1) begin errors++; $display("FAIL first_req_valid: got %b expected 1", o_rvalid); end
    endtask

    task automatic test_sequential();
        logic [15:0] reqs[$];
        logic [15:0] cons[$];
        logic [15:0] dat[$];
        do_reset();
        lat = 1; rdy_pct = 100; drv_instr_ready = 1'b1;
        for (int n = 0; n < 12; n++) begin
            cycle();
            if (o_req)  reqs.push_back(o_req_addr);
            if (o_cons) begin cons.push_back(o_pc); dat.push_back(o_instr); end
        end
        checks++;
        if (reqs.size() < 3 || cons.size() < 3) begin
            errors++; $display("FAIL seq_count: got reqs=%0d cons=%0d expected >=3 each", reqs.size(), cons.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (reqs[i] !== 16'(2 * i)) begin errors++; $display("FAIL seq_addr%0d: got %h expected %h", i, reqs[i], 16'(2 * i)); end
                checks++; if (cons[i] !== 16'(2 * i)) begin errors++; $display("FAIL seq_pc%0d: got %h expected %h", i, cons[i], 16'(2 * i)); end
                checks++; if (dat[i] !== (16'(2 * i) ^ key)) begin errors++; $display("FAIL seq_instr%0d: got %h expected %h", i, dat[i], 16'(2 * i) ^ key); end
            end
        end
    endtask

    task automatic test_backpressure();
        int nreq = 0;
        do_reset();
        lat = 1; rdy_pct = 100; drv_instr_ready = 1'b0;
        for (int n = 0; n < 12; n++) begin
            cycle();
            if (o_req) nreq++;
        end
        checks++; if (nreq != 4) begin errors++; $display("FAIL bp_requests: got %0d expected 4", nreq); end
        checks++; if (o_rvalid !== 1'b0) begin errors++; $display("FAIL bp_req_low: got %b expected 0", o_rvalid); end
        drv_instr_ready = 1'b1;
        cycle();
        checks++; if (o_rvalid !== 1'b0 || o_cons !== 1'b1) begin errors++; $display("FAIL bp_dequeue: got req=%b cons=%b expected req=0 cons=1", o_rvalid, o_cons); end
        drv_instr_ready = 1'b0;
        cycle();
        checks++; if (o_rvalid !== 1'b1) begin errors++; $display("FAIL bp_req_resume: got %b expected 1", o_rvalid); end
    endtask

    task automatic test_redirect();
        int          seen_valid = 0;
        logic        got_req = 1'b0, got_cons = 1'b0;
        logic [15:0] first_req = 16'h0, first_pc = 16'h0, first_instr = 16'h0;
        do_reset();
        lat = 3; rdy_pct = 100; drv_instr_ready = 1'b1;
        cycle();
        cycle();
        rdy_pct = 0; drv_redirect = 1'b1; drv_redirect_pc = 16'h0100;
        cycle();
        drv_redirect = 1'b0; rdy_pct = 100;
        for (int n = 0; n < 15; n++) begin
            cycle();
            if (n < 3 && o_ivalid) seen_valid++;
            if (o_req && !got_req) begin got_req = 1'b1; first_req = o_req_addr; end
            if (o_cons && !got_cons) begin got_cons = 1'b1; first_pc = o_pc; first_instr = o_instr; end
        end
        checks++; if (seen_valid != 0) begin errors++; $display("FAIL redir_dropped: got %0d valid cycles expected 0", seen_valid); end
        checks++; if (!got_req || first_req !== 16'h0100) begin errors++; $display("FAIL redir_addr: got %h expected 0100", first_req); end
        checks++; if (!got_cons || first_pc !== 16'h0100) begin errors++; $display("FAIL redir_pc: got %h expected 0100", first_pc); end
        checks++; if (first_instr !== (16'h0100 ^ key)) begin errors++; $display("FAIL redir_instr: got %h expected %h", first_instr, 16'h0100 ^ key); end
    endtask

    task automatic test_halt();
        int          nreq = 0, ncons = 0, post_req = 0;
        logic        got_req = 1'b0, got_cons = 1'b0;
        logic [15:0] first_req = 16'h0, first_pc = 16'h0;
        do_reset();
        lat = 2; rdy_pct = 100; drv_instr_ready = 1'b1;
        for (int n = 0; n < 20 && mem_addr !== 16'h0006; n++) begin
            cycle();
            nreq += int'(o_req); ncons += int'(o_cons);
        end
        drv_halt = 1'b1;
        cycle();
        nreq += int'(o_req); ncons += int'(o_cons);
        drv_halt = 1'b0;
        for (int n = 0; n < 12; n++) begin
            cycle();
            post_req += int'(o_req); ncons += int'(o_cons);
        end
        checks++; if (post_req != 0) begin errors++; $display("FAIL halt_no_req: got %0d expected 0", post_req); end
        checks++; if (o_halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b expected 1", o_halted); end
        checks++; if (ncons != nreq || nreq == 0) begin errors++; $display("FAIL halt_drain: got %0d consumed expected %0d", ncons, nreq); end
        drv_redirect = 1'b1; drv_redirect_pc = 16'h0020;
        cycle();
        drv_redirect = 1'b0;
        for (int n = 0; n < 10; n++) begin
            cycle();
            if (o_req && !got_req) begin got_req = 1'b1; first_req = o_req_addr; end
            if (o_cons && !got_cons) begin got_cons = 1'b1; first_pc = o_pc; end
        end
        checks++; if (o_halted !== 1'b0) begin errors++; $display("FAIL resume_flag: got %b expected 0", o_halted); end
        checks++; if (!got_req || first_req !== 16'h0020) begin errors++; $display("FAIL resume_addr: got %h expected 0020", first_req); end
        checks++; if (!got_cons || first_pc !== 16'h0020) begin errors++; $display("FAIL resume_pc: got %h expected 0020", first_pc); end
    endtask

    task automatic test_wrap();
        logic [15:0] reqs[$];
        logic [15:0] cons[$];
        do_reset();
        lat = 1; rdy_pct = 0; drv_instr_ready = 1'b1;
        drv_redirect = 1'b1; drv_redirect_pc = 16'hFFFE;
        cycle();
        drv_redirect = 1'b0; rdy_pct = 100;
        for (int n = 0; n < 10; n++) begin
            cycle();
            if (o_req)  reqs.push_back(o_req_addr);
            if (o_cons) cons.push_back(o_pc);
        end
        checks++;
        if (reqs.size() < 2 || cons.size() < 2) begin
            errors++; $display("FAIL wrap_count: got reqs=%0d cons=%0d expected >=2", reqs.size(), cons.size());
        end else begin
            checks++; if (reqs[0] !== 16'hFFFE || reqs[1] !== 16'h0000) begin errors++; $display("FAIL wrap_addr: got %h,%h expected fffe,0000", reqs[0], reqs[1]); end
            checks++; if (cons[0] !== 16'hFFFE || cons[1] !== 16'h0000) begin errors++; $display("FAIL wrap_pc: got %h,%h expected fffe,0000", cons[0], cons[1]); end
        end
    endtask

    task automatic test_bypass();
        logic exp_first;
`ifdef FETCH_BYPASS_EN
        exp_first = 1'b1;
`else
        exp_first = 1'b0;
`endif
        do_reset();
        key = 16'h0000 ^ 16'hA123;
        lat = 1; rdy_pct = 100; drv_instr_ready = 1'b0;
        cycle();
        rdy_pct = 0;
        cycle();
        checks++; if (o_ivalid !== exp_first) begin errors++; $display("FAIL bypass_arrival_valid: got %b expected %b", o_ivalid, exp_first); end
        if (exp_first) begin
            checks++; if (o_instr !== 16'hA123) begin errors++; $display("FAIL bypass_arrival_instr: got %h expected a123", o_instr); end
        end
        cycle();
        checks++; if (o_ivalid !== 1'b1 || o_instr !== 16'hA123 || o_pc !== 16'h0000) begin
            errors++; $display("FAIL bypass_next: got v=%b instr=%h pc=%h expected v=1 instr=a123 pc=0000", o_ivalid, o_instr, o_pc);
        end
        key = 16'h5A5A;
    endtask

    task automatic test_random();
        logic [15:0] exp_req, exp_cons;
        logic        hm;
        do_reset();
        exp_req = 16'h0; exp_cons = 16'h0; hm = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (n == 300) begin
                do_reset();
                exp_req = 16'h0; exp_cons = 16'h0; hm = 1'b0;
            end
            lat             = $urandom_range(1, 4);
            rdy_pct         = 70;
            drv_instr_ready = ($urandom_range(99) < 60);
            drv_redirect    = ($urandom_range(99) < 4);
            drv_redirect_pc = 16'($urandom) & 16'hFFFE;
            drv_halt        = ($urandom_range(99) < 3);
            cycle();
            checks++; if (o_halted !== hm) begin errors++; $display("FAIL rnd_halted n=%0d: got %b expected %b", n, o_halted, hm); end
            if (hm) begin
                checks++; if (o_rvalid !== 1'b0) begin errors++; $display("FAIL rnd_req_in_halt n=%0d: got %b expected 0", n, o_rvalid); end
            end
            if (o_req) begin
                checks++; if (o_req_addr !== exp_req) begin errors++; $display("FAIL rnd_addr n=%0d: got %h expected %h", n, o_req_addr, exp_req); end
                exp_req = exp_req + 16'd2;
            end
            if (o_cons) begin
                checks++; if (o_pc !== exp_cons || o_instr !== (exp_cons ^ key)) begin
                    errors++; $display("FAIL rnd_instr n=%0d: got pc=%h instr=%h expected pc=%h instr=%h", n, o_pc, o_instr, exp_cons, exp_cons ^ key);
                end
                exp_cons = exp_cons + 16'd2;
            end
            if (drv_redirect) begin exp_req = drv_redirect_pc; exp_cons = drv_redirect_pc; end
            if (drv_halt) hm = 1'b1;
            else if (drv_redirect) hm = 1'b0;
        end
        clear_drives();
    endtask

    initial begin
        rst = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 16'h0;
        instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0; halt = 1'b0;
        clear_drives();
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_bypass();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, 16, fetch address width in bits.
REQ-002 SHALL have parameter INSTR_W, 16, instruction width in bits (multiple of 8).
REQ-003 SHALL have parameter DEPTH, 4, instruction queue entries (power of two, >=2).
REQ-004 SHALL have parameter RESET_PC, 0, fetch address loaded on reset.
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port mem_req_valid  output  1  fetch request valid.
REQ-008 SHALL have port mem_req_ready  input  1  memory accepts request.
REQ-009 SHALL have port mem_addr  output  ADDR_W  request address (the current fetch pc).
REQ-010 SHALL have port mem_rsp_valid  input  1  in-order response valid, any latency >=1.
REQ-011 SHALL have port mem_rsp_data  input  INSTR_W  response instruction.
REQ-012 SHALL have port instr_valid  output  1  queue head valid.
REQ-013 SHALL have port instr_ready  input  1  consumer takes head.
REQ-014 SHALL have port instr  output  INSTR_W  head instruction.
REQ-015 SHALL have port instr_pc  output  ADDR_W  address of head instruction.
REQ-016 SHALL have port redirect_valid  input  1  branch/jump taken, flush.
REQ-017 SHALL have port redirect_pc  input  ADDR_W  new fetch address.
REQ-018 SHALL have port halt  input  1  stop issuing fetches.
REQ-019 SHALL have port halted  output  1  state is HALTED.

Function
REQ-020 SHALL have states FETCH, HALTED; FETCH->HALTED on halt; HALTED->FETCH only on redirect_valid without halt; redirect_valid with halt SHALL load redirect_pc and enter/stay HALTED.
REQ-021 SHALL assert mem_req_valid only in FETCH and only when count + outstanding + discard < DEPTH; mem_req_valid SHALL not depend combinationally on redirect_valid or halt.
REQ-022 SHALL, on mem_req_valid & mem_req_ready, advance pc by INSTR_W/8 next cycle, modulo 2^ADDR_W (wrap to 0).
REQ-023 SHALL record each request address in a tag FIFO so instr_pc matches its instruction.
REQ-024 SHALL, when discard = 0, enqueue each response with its tag; discard > 0 SHALL drop the response and decrement discard.
REQ-025 SHALL dequeue the head on instr_valid & instr_ready; enqueue and dequeue in one cycle SHALL leave count unchanged.
REQ-026 SHALL, on redirect_valid: pc <= redirect_pc, queue emptied, discard <= discard + outstanding + req_fire - rsp_valid, outstanding <= 0; a request accepted or response arriving that cycle SHALL be squashed.
REQ-027 SHALL ignore instr_ready in a redirect cycle (flush wins over dequeue).
REQ-028 SHALL keep in-flight responses enqueued after halt; halt SHALL not flush.
REQ-029 SHALL never overflow the queue (guaranteed by REQ-021 credit); counters sized clog2(DEPTH+1).

Reset
REQ-030 SHALL on rst: pc=RESET_PC, state FETCH, count/outstanding/discard=0, mem_req_valid=0, instr_valid=0, halted=0; instr, instr_pc SHALL be 0.
REQ-031 SHALL first assert mem_req_valid the cycle after rst deasserts; rst mid-operation SHALL discard everything without dropping future responses (memory is reset concurrently).

Configuration
REQ-032 SHALL, with FETCH_BYPASS_EN defined, present a response on instr the same cycle when queue empty, discard = 0 and no redirect; consumed that cycle if instr_ready, else enqueued.
REQ-033 SHALL, without FETCH_BYPASS_EN, show responses on instr no earlier than the cycle after arrival.

Structure
REQ-034 SHALL place state enum, default parameter values and the halt opcode constant 4'hF in package fetch_pkg.
REQ-035 SHALL implement queue storage (instr+pc, count, full/empty) as sub-module fetch_fifo, instantiated once.

Verification
REQ-036 Reset, ready=1, 1-cycle memory -> addresses 0x0000,0x0002,0x0004; instr_pc tracks each instr.
REQ-037 instr_ready=0, DEPTH=4 -> exactly 4 requests issued, mem_req_valid low until one dequeue.
REQ-038 redirect to 0x0100 with 2 outstanding, 3-cycle memory -> 2 responses dropped, next instr_pc=0x0100.
REQ-039 halt at pc 0x0006 -> no further requests, queued instructions still drained, halted=1; redirect 0x0020 -> resumes.
REQ-040 pc 0xFFFE issued -> next address 0x0000.
REQ-041 bypass on vs off, empty queue, response 0xA123 -> instr_valid same cycle vs one cycle later.
